mem_stage_lsu: RTL and testbench

- Memory-stage load/store unit plus MEM/WB pipeline register.
- Consumes the registered EX/MEM bundle (control, ALU result, store data, rd, PC+4) and drives a single-port data-memory request/acknowledge bus.
- Aligns and sign/zero-extends load data, then registers the writeback bundle for the W stage.
- Stalls upstream while a memory access is outstanding, and aborts any access that exceeds a timeout.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/mem_stage_lsu_load_extend.sv | 32 +++
 rtl/mem_stage_lsu.sv | 191 +++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: result-select and funct3 encodings, LSU state type,
// and the alignment rule used by the memory stage.
package pipe_pkg;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } lsu_state_t;

  // Size comes from funct3[1:0] only, so LHU is checked like LH.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    return ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
           ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_stage_lsu_load_extend.sv
// Load data alignment: picks the addressed byte/half of the read word and
// sign- or zero-extends it according to funct3.
module load_extend
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rdata,
  input  logic [1:0]       i_addr_lo,
  input  logic [2:0]       i_funct3,
  output logic [WIDTH-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    o_data = '0;
    case (i_funct3)
      F3_B:    o_data = {{(WIDTH-8){w_byte[7]}}, w_byte};
      F3_BU:   o_data = {{(WIDTH-8){1'b0}}, w_byte};
      F3_H:    o_data = {{(WIDTH-16){w_half[15]}}, w_half};
      F3_HU:   o_data = {{(WIDTH-16){1'b0}}, w_half};
      F3_W:    o_data = i_rdata;
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit with MEM/WB pipeline register. Holds the pipe
// while a data-memory access is outstanding and aborts it after TIMEOUT cycles.
module mem_stage_lsu
  import pipe_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWriteM,
  input  logic [1:0]       ResultSrcM,
  input  logic             MemWriteM,
  input  logic [2:0]       Funct3M,
  input  logic [WIDTH-1:0] ALUResultM,
  input  logic [WIDTH-1:0] WriteDataM,
  input  logic [4:0]       RdM,
  input  logic [WIDTH-1:0] PCPlus4M,
  output logic             StallM,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  output logic [3:0]       dmem_be,
  input  logic [WIDTH-1:0] dmem_rdata,
  input  logic             dmem_ack,
  output logic             RegWriteW,
  output logic [1:0]       ResultSrcW,
  output logic [WIDTH-1:0] ReadDataW,
  output logic [WIDTH-1:0] ALUResultW,
  output logic [4:0]       RdW,
  output logic [WIDTH-1:0] PCPlus4W,
  output logic             ErrW,
  output lsu_state_t       o_lsu_state
);

  localparam int            CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  lsu_state_t       r_state;
  lsu_state_t       w_next_state;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_next_cnt;
  logic             w_access;
  logic             w_load;
  logic             w_misaligned;
  logic             w_go;
  logic             w_req;
  logic             w_stall;
  logic             w_err;
  logic [1:0]       w_res_src;
  logic [WIDTH-1:0] w_load_data;

  assign w_access     = MemWriteM | (ResultSrcM == RES_MEM);
  assign w_load       = (ResultSrcM == RES_MEM) & ~MemWriteM;
  assign w_misaligned = is_misaligned(Funct3M, ALUResultM[1:0]);
  assign w_go         = w_access & ~w_misaligned;

  // The reserved select code behaves as an ALU result downstream.
  always_comb begin
    w_res_src = RES_ALU;
    case (ResultSrcM)
      RES_MEM: w_res_src = RES_MEM;
      RES_PC4: w_res_src = RES_PC4;
      default: w_res_src = RES_ALU;
    endcase
  end

  assign dmem_addr = {ALUResultM[WIDTH-1:2], 2'b00};
  assign dmem_we   = MemWriteM & w_req;
  assign dmem_req  = w_req;
  assign StallM    = w_stall;

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = WriteDataM;
    if (MemWriteM) begin
      case (Funct3M[1:0])
        2'b00: begin
          dmem_be    = 4'b0001 << ALUResultM[1:0];
          dmem_wdata = {(WIDTH/8){WriteDataM[7:0]}};
        end
        2'b01: begin
          dmem_be    = 4'b0011 << ALUResultM[1:0];
          dmem_wdata = {(WIDTH/16){WriteDataM[15:0]}};
        end
        default: ;
      endcase
    end
  end

  load_extend #(.WIDTH(WIDTH)) u_load_extend (
    .i_rdata   (dmem_rdata),
    .i_addr_lo (ALUResultM[1:0]),
    .i_funct3  (Funct3M),
    .o_data    (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_go && !dmem_ack) begin
          w_next_state = WAIT;
          w_next_cnt   = CW'(1);
        end
      end
      WAIT: begin
        if (dmem_ack || (r_cnt == CNT_MAX)) begin
          w_next_state = IDLE;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  // An ack in the final WAIT cycle wins over the timeout abort.
  always_comb begin
    w_req   = 1'b0;
    w_stall = 1'b0;
    w_err   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_go) begin
          w_req   = 1'b1;
          w_stall = ~dmem_ack;
        end else if (w_access) begin
          w_err = 1'b1;
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          w_req = 1'b1;
        end else if (r_cnt == CNT_MAX) begin
          w_err = 1'b1;
        end else begin
          w_req   = 1'b1;
          w_stall = 1'b1;
        end
      end
      default: ;
    endcase
    if (rst) begin
      w_req   = 1'b0;
      w_stall = 1'b0;
    end
  end

  assign o_lsu_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= '0;
      ReadDataW  <= '0;
      ALUResultW <= '0;
      RdW        <= '0;
      PCPlus4W   <= '0;
      ErrW       <= 1'b0;
    end else if (w_stall) begin
      RegWriteW <= 1'b0;
      ErrW      <= 1'b0;
    end else begin
      RegWriteW  <= RegWriteM & ~w_err;
      ResultSrcW <= w_res_src;
      ReadDataW  <= (w_load && !w_err) ? w_load_data : '0;
      ALUResultW <= ALUResultM;
      RdW        <= RdM;
      PCPlus4W   <= PCPlus4M;
      ErrW       <= w_err;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized bench for mem_stage_lsu against a transaction-level model of the
// memory stage, plus directed scenarios with literal expectations.
module tb_mem_stage_lsu;
  import pipe_pkg::*;

  localparam int TIMEOUT = 4;

  typedef struct packed {
    logic        rw;
    logic [1:0]  rs;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [31:0] pc4;
    logic        err;
  } wb_t;

  localparam int WB_W = $bits(wb_t);

  typedef struct {
    logic        rw;
    logic [1:0]  rs;
    logic        mw;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [31:0] pc4;
    int          delay;
    logic [31:0] rdata;
  } op_t;

  logic        clk;
  logic        rst;
  logic        RegWriteM;
  logic [1:0]  ResultSrcM;
  logic        MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [4:0]  RdM;
  logic [31:0] PCPlus4M;
  logic        StallM;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ReadDataW;
  logic [31:0] ALUResultW;
  logic [4:0]  RdW;
  logic [31:0] PCPlus4W;
  logic        ErrW;
  lsu_state_t  o_lsu_state;

  mem_stage_lsu #(.WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .RegWriteM   (RegWriteM),
    .ResultSrcM  (ResultSrcM),
    .MemWriteM   (MemWriteM),
    .Funct3M     (Funct3M),
    .ALUResultM  (ALUResultM),
    .WriteDataM  (WriteDataM),
    .RdM         (RdM),
    .PCPlus4M    (PCPlus4M),
    .StallM      (StallM),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_be     (dmem_be),
    .dmem_rdata  (dmem_rdata),
    .dmem_ack    (dmem_ack),
    .RegWriteW   (RegWriteW),
    .ResultSrcW  (ResultSrcW),
    .ReadDataW   (ReadDataW),
    .ALUResultW  (ALUResultW),
    .RdW         (RdW),
    .PCPlus4W    (PCPlus4W),
    .ErrW        (ErrW),
    .o_lsu_state (o_lsu_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [WB_W-1:0] exp_q[$];
  int              n_vec = 0;
  int              n_miss = 0;
  logic            chk_en = 1'b0;
  logic            exp_req;
  logic            exp_stall;
  logic            exp_we;
  lsu_state_t      exp_state;
  logic [31:0]     exp_addr;
  logic [31:0]     exp_wdata;
  logic [3:0]      exp_be;
  wb_t             m_w;

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic is_access(input op_t o);
    return o.mw || (o.rs == 2'b01);
  endfunction

  function automatic logic is_load(input op_t o);
    return (o.rs == 2'b01) && !o.mw;
  endfunction

  function automatic logic is_mis(input op_t o);
    int a = int'(o.alu[1:0]);
    if (o.f3[1:0] == 2'b01) return (a % 2) != 0;
    if (o.f3[1:0] == 2'b10) return a != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_be(input op_t o);
    int a = int'(o.alu[1:0]);
    if (!o.mw) return 4'hF;
    if (o.f3[1:0] == 2'b00) return 4'(1 << a);
    if (o.f3[1:0] == 2'b01) return 4'(3 << a);
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input op_t o);
    if (o.f3[1:0] == 2'b00) return (o.wd & 32'hFF) * 32'h01010101;
    if (o.f3[1:0] == 2'b01) return (o.wd & 32'hFFFF) * 32'h00010001;
    return o.wd;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [1:0] a, input logic [2:0] f3);
    logic [31:0] b = (rd >> (8 * int'(a))) & 32'hFF;
    logic [31:0] h = (rd >> (8 * int'(a))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b + 32'hFFFFFF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
      3'd5:    return h;
      3'd2:    return rd;
      default: return 32'h0;
    endcase
  endfunction

  function automatic wb_t model_norm(input op_t o);
    wb_t w;
    w.rw    = o.rw;
    w.rs    = (o.rs == 2'b11) ? 2'b00 : o.rs;
    w.rdata = is_load(o) ? model_load(o.rdata, o.alu[1:0], o.f3) : 32'h0;
    w.alu   = o.alu;
    w.rd    = o.rd;
    w.pc4   = o.pc4;
    w.err   = 1'b0;
    return w;
  endfunction

  function automatic wb_t model_err(input op_t o);
    wb_t w = model_norm(o);
    w.rw    = 1'b0;
    w.rdata = 32'h0;
    w.err   = 1'b1;
    return w;
  endfunction

  function automatic wb_t bubble();
    wb_t w = m_w;
    w.rw  = 1'b0;
    w.err = 1'b0;
    return w;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input op_t o, input logic ack, input logic r,
                             input logic e_req, input logic e_stall,
                             input lsu_state_t e_state, input wb_t nxt);
    @(posedge clk);
    #1;
    rst        = r;
    RegWriteM  = o.rw;
    ResultSrcM = o.rs;
    MemWriteM  = o.mw;
    Funct3M    = o.f3;
    ALUResultM = o.alu;
    WriteDataM = o.wd;
    RdM        = o.rd;
    PCPlus4M   = o.pc4;
    dmem_rdata = o.rdata;
    dmem_ack   = ack;
    exp_req    = e_req;
    exp_stall  = e_stall;
    exp_state  = e_state;
    exp_we     = o.mw;
    exp_addr   = {o.alu[31:2], 2'b00};
    exp_be     = model_be(o);
    exp_wdata  = model_wdata(o);
    exp_q.push_back(nxt);
    m_w        = nxt;
    chk_en     = 1'b1;
  endtask

  // One M-stage instruction, held for as many cycles as the memory takes.
  task automatic run_op(input op_t o);
    if (!is_access(o) || is_mis(o)) begin
      drive_cycle(o, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, IDLE,
                  is_access(o) ? model_err(o) : model_norm(o));
    end else begin
      logic ok  = (o.delay >= 0) && (o.delay <= TIMEOUT);
      int   nst = ok ? o.delay : TIMEOUT;
      for (int i = 0; i < nst; i++)
        drive_cycle(o, 1'b0, 1'b0, 1'b1, 1'b1, (i == 0) ? IDLE : WAIT, bubble());
      drive_cycle(o, ok, 1'b0, ok, 1'b0, (nst == 0) ? IDLE : WAIT,
                  ok ? model_norm(o) : model_err(o));
    end
  endtask

  function automatic op_t nop_op();
    op_t o;
    o.rw = 1'b0; o.rs = 2'b00; o.mw = 1'b0; o.f3 = 3'd0;
    o.alu = 32'h0; o.wd = 32'h0; o.rd = 5'd0; o.pc4 = 32'h0;
    o.delay = 0; o.rdata = 32'h0;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int  r;
    o.rw    = 1'($urandom_range(0, 1));
    o.rs    = 2'($urandom_range(0, 3));
    o.mw    = ($urandom_range(0, 3) == 0);
    o.f3    = 3'($urandom_range(0, 7));
    o.alu   = $urandom;
    if ($urandom_range(0, 1) == 1) o.alu[1:0] = 2'b00;
    o.wd    = $urandom;
    o.rd    = 5'($urandom_range(0, 31));
    o.pc4   = $urandom;
    o.rdata = $urandom;
    r       = $urandom_range(0, 9);
    o.delay = (r < 2) ? -1 : (r < 5) ? 0 : $urandom_range(1, TIMEOUT + 1);
    return o;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", 128'(StallM), 128'(exp_stall));
      check("req", 128'(dmem_req), 128'(exp_req));
      check("state", 128'(o_lsu_state), 128'(exp_state));
      if (exp_req) begin
        check("addr", 128'(dmem_addr), 128'(exp_addr));
        check("be", 128'(dmem_be), 128'(exp_be));
        check("we", 128'(dmem_we), 128'(exp_we));
        if (exp_we) check("wdata", 128'(dmem_wdata), 128'(exp_wdata));
      end
      if (exp_q.size() >= 2) begin
        logic [WB_W-1:0] e;
        e = exp_q.pop_front();
        check("wb", 128'({RegWriteW, ResultSrcW, ReadDataW, ALUResultW, RdW, PCPlus4W, ErrW}),
              128'(e));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    op_t o;
    op_t nop;
    rst = 1'b1; RegWriteM = 1'b0; ResultSrcM = 2'b00; MemWriteM = 1'b0; Funct3M = 3'd0;
    ALUResultM = 32'h0; WriteDataM = 32'h0; RdM = 5'd0; PCPlus4M = 32'h0;
    dmem_rdata = 32'h0; dmem_ack = 1'b0;
    m_w = '0;
    nop = nop_op();

    drive_cycle(nop, 1'b0, 1'b1, 1'b0, 1'b0, IDLE, '0);
    drive_cycle(nop, 1'b1, 1'b1, 1'b0, 1'b0, IDLE, '0);

    // ALU op passes through in one cycle
    o = nop; o.rw = 1'b1; o.alu = 32'h1234; o.rd = 5'd5; o.pc4 = 32'h44;
    run_op(o);
    run_op(nop);
    @(negedge clk);
    check("alu_regwrite", 128'(RegWriteW), 128'(1'b1));
    check("alu_result", 128'(ALUResultW), 128'(32'h1234));
    check("alu_rd", 128'(RdW), 128'(5'd5));

    // SB to byte 3, acked immediately
    o = nop; o.mw = 1'b1; o.f3 = 3'd0; o.alu = 32'h103; o.wd = 32'hAABBCCDD; o.delay = 0;
    run_op(o);
    @(negedge clk);
    check("sb_addr", 128'(dmem_addr), 128'(32'h100));
    check("sb_be", 128'(dmem_be), 128'(4'b1000));
    check("sb_wdata", 128'(dmem_wdata), 128'(32'hDDDDDDDD));
    check("sb_stall", 128'(StallM), 128'(1'b0));

    // LB / LBU with three wait cycles
    o = nop; o.rw = 1'b1; o.rs = 2'b01; o.f3 = 3'd0; o.alu = 32'h102; o.rd = 5'd7;
    o.delay = 3; o.rdata = 32'h00800000;
    run_op(o);
    run_op(nop);
    @(negedge clk);
    check("lb_data", 128'(ReadDataW), 128'(32'hFFFFFF80));
    o.f3 = 3'd4;
    run_op(o);
    run_op(nop);
    @(negedge clk);
    check("lbu_data", 128'(ReadDataW), 128'(32'h00000080));

    // Misaligned LW: no request, error next cycle
    o = nop; o.rw = 1'b1; o.rs = 2'b01; o.f3 = 3'd2; o.alu = 32'h2; o.rd = 5'd9;
    run_op(o);
    run_op(nop);
    @(negedge clk);
    check("mis_err", 128'(ErrW), 128'(1'b1));
    check("mis_regwrite", 128'(RegWriteW), 128'(1'b0));

    // Load that is never acknowledged times out
    o = nop; o.rw = 1'b1; o.rs = 2'b01; o.f3 = 3'd2; o.alu = 32'h40; o.rd = 5'd3; o.delay = -1;
    run_op(o);
    run_op(nop);
    @(negedge clk);
    check("to_err", 128'(ErrW), 128'(1'b1));
    check("to_state", 128'(o_lsu_state), 128'(IDLE));

    // Reset during the second WAIT cycle drops the access; a later ack is ignored
    drive_cycle(o, 1'b0, 1'b0, 1'b1, 1'b1, IDLE, bubble());
    drive_cycle(o, 1'b0, 1'b0, 1'b1, 1'b1, WAIT, bubble());
    drive_cycle(o, 1'b0, 1'b1, 1'b0, 1'b0, WAIT, '0);
    drive_cycle(nop, 1'b1, 1'b0, 1'b0, 1'b0, IDLE, model_norm(nop));
    @(negedge clk);
    check("rst_wb_zero", 128'({RegWriteW, ResultSrcW, ReadDataW, ALUResultW, RdW, PCPlus4W, ErrW}),
          128'(0));
    check("rst_state", 128'(o_lsu_state), 128'(IDLE));

    for (int i = 0; i < 300; i++) begin
      run_op(rand_op());
    end
    run_op(nop);
    run_op(nop);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
